serial_adder_param: RTL and testbench
=====================================

Name: serial_adder_param

Overview:
- Parametrised multi-cycle successor to the team's 1-bit full adder (S = A^B^CIN, COUT = A&B | CIN&(A^B)).
- Adds two WIDTH-bit operands plus a carry-in, DIGIT bits per clock, LSB digit first, with one carry flop chaining the digits.
- start/busy/done handshake; result and carry-out are held until the next accepted start.
- Used wherever area matters more than latency: the datapath shares one DIGIT-bit adder slice across the word.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits added per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when idle
- a  input  WIDTH  operand A, captured when start is accepted
- b  input  WIDTH  operand B, captured when start is accepted
- cin  input  1  carry-in, captured when start is accepted
- busy  output  1  high while digits are being added
- done  output  1  one-cycle pulse: sum and cout are valid
- sum  output  WIDTH  result, held until the next accepted start
- cout  output  1  carry out of the MSB, held with sum

Behaviour:
- Reset: rst_n low asynchronously clears all registers.
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Digit counter, operand registers and carry flop all cleared.
- N = WIDTH/DIGIT digits. Counter width is clog2(N), minimum 1.
- States:
  - IDLE: start=1 captures a, b and cin; counter <= 0; state -> RUN; busy <= 1. done <= 0 in every IDLE cycle.
  - RUN: each cycle adds digit i = counter, covering bits [i*DIGIT +: DIGIT] of the captured operands, plus the carry flop.
    - Digit sum is written into sum[i*DIGIT +: DIGIT].
    - Carry flop updates with the digit carry-out.
    - Digit arithmetic is DIGIT+1 bits wide; there is no truncation inside a digit.
  - RUN, last digit (counter = N-1): on that edge, cout <= final carry, done <= 1, busy <= 0, state -> IDLE.
- Latency: start accepted at edge k. The N digits are computed on edges k+1 through k+N. done is high for exactly the one cycle after edge k+N.
- Back-to-back: a start sampled during the done cycle is accepted (state is IDLE), so throughput is one add per N+1 cycles.
- sum is updated digit by digit during RUN, so intermediate values are visible; it is only valid while done=1 or afterwards.
- start while busy=1: ignored, no queueing; the in-flight operands are unaffected.
- Operand inputs may change freely after acceptance.
- Wrap-around: the result is mod 2^WIDTH and overflow is reported only via cout. There is no signed overflow flag.
- DIGIT=WIDTH: N=1, so done arrives one cycle after acceptance.
- Reset mid-operation: aborts immediately, outputs go to reset values, and no done is issued.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), captured with start.
  - sub=1: B is inverted and the carry flop is seeded with 1 (cin is ignored), giving a - b mod 2^WIDTH. cout=1 means no borrow.
  - sub=0: identical to the undefined build.
- Undefined: the sub port does not exist and the block always adds. Timing is identical in both builds.

Test Plan:
- WIDTH=8, DIGIT=1: start with a=0x5A, b=0x3C, cin=0 -> done exactly 8 cycles after acceptance; sum=0x96, cout=0; busy high for those 8 cycles.
- WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 started in the done cycle -> accepted, sum=0x01, cout=0.
- WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0000, cin=1 -> done 4 cycles after acceptance, sum=0x0000, cout=1.
- Busy-ignore: accept a=0x11, b=0x22, then pulse start with a=0xF0, b=0x0F two cycles later -> result is 0x33; only one done pulse.
- Reset mid-op: rst_n low at cycle 3 of an 8-cycle add -> busy, done, sum and cout read 0 immediately; no done after release. A fresh add afterwards completes correctly.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8, DIGIT=2: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1. a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder_param_if.sv
// Start/busy/done handshake and operand/result bus for serial_adder_param.
// The sub port exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_param_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_param.sv
// Digit-serial adder: WIDTH-bit a + b + cin, DIGIT bits per clock, LSB digit first.
// Define SERIAL_ADDER_SUB_EN to add a sub input that turns the operation into a - b.
module serial_adder_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_adder_param_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  int unsigned      base;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   digit;

  // The single shared DIGIT-bit slice; one extra bit keeps the digit carry.
  always_comb begin
    base  = int'(cnt_q) * DIGIT;
    a_dig = a_q[base +: DIGIT];
    b_dig = b_q[base +: DIGIT];
    digit = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  end

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d = bus.a;
`ifdef SERIAL_ADDER_SUB_EN
          // Two's-complement subtract: invert b and seed the carry with 1.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1   : bus.cin;
`else
          b_d     = bus.b;
          carry_d = bus.cin;
`endif
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: DIGIT] = digit[DIGIT-1:0];
        carry_d              = digit[DIGIT];
        if (cnt_q == CW'(N - 1)) begin
          cout_d  = digit[DIGIT];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_param.sv
// Directed bench for serial_adder_param: 8/1, 16/4 and 8/2 instances sharing clk/rst_n.
// The subtract vectors on the 8/2 instance run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_param_if #(.WIDTH(8))  i8  ();
  serial_adder_param_if #(.WIDTH(16)) i16 ();
  serial_adder_param_if #(.WIDTH(8))  i2  ();

  serial_adder_param #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
  serial_adder_param #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));
  serial_adder_param #(.WIDTH(8),  .DIGIT(2)) dut2  (.clk(clk), .rst_n(rst_n), .bus(i2));

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        cout;
    logic [15:0] sum;
  } obs_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s);
    case (sel)
      0: begin i8.start = st;  i8.a = a[7:0];  i8.b = b[7:0];  i8.cin = c;  end
      1: begin i16.start = st; i16.a = a;      i16.b = b;      i16.cin = c; end
      default: begin
        i2.start = st; i2.a = a[7:0]; i2.b = b[7:0]; i2.cin = c;
`ifdef SERIAL_ADDER_SUB_EN
        i2.sub = s;
`endif
      end
    endcase
    if (s === 1'bz) $display("unexpected z on sub");
  endtask

  function automatic obs_t obs(input int sel);
    obs_t o;
    case (sel)
      0:       o = {i8.busy,  i8.done,  i8.cout,  8'h00, i8.sum};
      1:       o = {i16.busy, i16.done, i16.cout, i16.sum};
      default: o = {i2.busy,  i2.done,  i2.cout,  8'h00, i2.sum};
    endcase
    return o;
  endfunction

  // Call at #1 after an edge with the DUT idle (or in its done cycle). Returns in the done cycle.
  task automatic run_op(input int sel, input int n, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic [15:0] es, input logic ec,
                        input string tag);
    obs_t o;
    drive(sel, 1'b1, a, b, c, s);
    @(posedge clk); #1;
    drive(sel, 1'b0, ~a, ~b, ~c, ~s);
    o = obs(sel);
    check({tag, "/accept_busy"}, 32'(o.busy), 32'd1);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      o = obs(sel);
      check($sformatf("%s/busy_done@%0d", tag, i), 32'({o.busy, o.done}),
            (i == n) ? 32'b01 : 32'b10);
    end
    check({tag, "/sum"},  32'(o.sum),  32'(es));
    check({tag, "/cout"}, 32'(o.cout), 32'(ec));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    obs_t o;
    int   dones;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Reset values
    #12;
    for (int s = 0; s < 3; s++) begin
      o = obs(s);
      check($sformatf("reset%0d/outputs", s), 32'(o), 32'd0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // 8/1: basic add, then overflow followed by a back-to-back start in the done cycle
    run_op(0, 8, 16'h5A, 16'h3C, 1'b0, 1'b0, 16'h96, 1'b0, "add_5a_3c");
    idle(1);
    o = obs(0);
    check("after_done/done_low", 32'(o.done), 32'd0);
    check("after_done/sum_held", 32'(o.sum),  32'h96);
    run_op(0, 8, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, "add_ff_01");
    run_op(0, 8, 16'h00, 16'h00, 1'b1, 1'b0, 16'h01, 1'b0, "b2b_cin");
    idle(2);

    // 8/1: start while busy is ignored and produces no second done
    drive(0, 1'b1, 16'h11, 16'h22, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h00, 16'h00, 1'b0, 1'b0);
    dones = 0;
    for (int i = 1; i <= 18; i++) begin
      if (i == 3) drive(0, 1'b1, 16'hF0, 16'h0F, 1'b0, 1'b0);
      if (i == 4) drive(0, 1'b0, 16'h00, 16'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      o = obs(0);
      if (o.done) dones++;
      if (i == 8) check("busy_ignore/sum", 32'(o.sum), 32'h33);
    end
    check("busy_ignore/done_count", 32'(dones), 32'd1);

    // 8/1: reset mid-operation, with cout=1 left over from a prior add
    run_op(0, 8, 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, "pre_reset");
    idle(1);
    drive(0, 1'b1, 16'hFF, 16'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h00, 16'h00, 1'b0, 1'b0);
    idle(3);
    o = obs(0);
    check("mid_op/partial_sum", 32'(o.sum), 32'h07);
    rst_n = 1'b0;
    #1;
    o = obs(0);
    check("mid_op/reset_outputs", 32'(o), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (obs(0).done) dones++;
    end
    check("mid_op/no_done_after_release", 32'(dones), 32'd0);
    run_op(0, 8, 16'h7F, 16'h01, 1'b1, 1'b0, 16'h81, 1'b0, "post_reset");

    // 16/4: N=4
    run_op(1, 4, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, "w16_ffff_cin");
    idle(1);
    run_op(1, 4, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, "w16_1234_4321");
    idle(1);
    run_op(1, 4, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, "w16_msb_wrap");

    // 8/2: plain add, and subtract when the feature is built in
    run_op(2, 4, 16'h10, 16'h01, 1'b0, 1'b0, 16'h11, 1'b0, "d2_add");
    idle(1);
    run_op(2, 4, 16'hC8, 16'h64, 1'b1, 1'b0, 16'h2D, 1'b1, "d2_add_carry");
`ifdef SERIAL_ADDER_SUB_EN
    idle(1);
    run_op(2, 4, 16'h10, 16'h01, 1'b0, 1'b1, 16'h0F, 1'b1, "d2_sub_10_01");
    idle(1);
    run_op(2, 4, 16'h01, 16'h02, 1'b1, 1'b1, 16'hFF, 1'b0, "d2_sub_01_02");
`endif
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
